// File: rtl/riscv_l1_arb_pkg.sv
// Shared types for the L1 data-cache port arbiter: FSM states, requester ids
// and the latched request record.
package riscv_l1_arb_pkg;

  localparam int CNT_W   = 4;
  localparam int N_PORTS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_MEM = 1'b0,
    PORT_AUX = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } l1_req_t;

endpackage

// File: rtl/riscv_l1_arb_pick.sv
// Combinational winner select: memory stage has priority unless the aux
// requester has waited through STARVE_LIMIT consecutive memory-stage grants.
module riscv_l1_arb_pick
  import riscv_l1_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             launch,
  input  logic [1:0]       valid,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic [1:0]       grant
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic starved;
  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    grant = '0;
    if (launch) begin
      if (valid[PORT_AUX] && (!valid[PORT_MEM] || starved)) begin
        grant[PORT_AUX] = 1'b1;
      end else if (valid[PORT_MEM]) begin
        grant[PORT_MEM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_l1d_port_arbiter.sv
// Two-requester arbiter for the single L1 data-cache port: latches one request,
// holds the command until l1_ready, and returns a registered done pulse.
module riscv_l1d_port_arbiter
  import riscv_l1_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req0_grant,
  output logic        req1_grant,
  output logic        req0_done,
  output logic        req1_done,
  output logic [31:0] rsp_rdata,
  output logic [31:0] l1_addr,
  output logic        l1_read,
  output logic        l1_write,
  output logic [31:0] l1_wdata,
  input  logic [31:0] l1_rdata,
  input  logic        l1_ready,
  output logic        busy
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e         state_reg;
  logic [CNT_W-1:0]   starve_cnt_reg;
  logic               l1_read_reg;
  logic               l1_write_reg;
  logic [N_PORTS-1:0] done_reg;
  logic [N_PORTS-1:0] done_next;
  l1_req_t            req_lat_reg;
  l1_req_t            req_sel;
  arb_port_e          owner_reg;
  logic [31:0]        rsp_rdata_reg;
  logic               launch;
  logic               complete;
  logic [1:0]         grant;

  // A completing transaction frees the port in the same cycle, so the next
  // request can launch without a bubble.
  assign complete = (state_reg == BUSY) && l1_ready;
  assign launch   = (state_reg == IDLE) || l1_ready;

  riscv_l1_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .launch    (launch),
    .valid     ({req1_valid, req0_valid}),
    .starve_cnt(starve_cnt_reg),
    .grant     (grant)
  );

  always_comb begin
    if (grant[PORT_AUX]) begin
      req_sel.we    = req1_we;
      req_sel.addr  = req1_addr;
      req_sel.wdata = req1_wdata;
    end else begin
      req_sel.we    = req0_we;
      req_sel.addr  = req0_addr;
      req_sel.wdata = req0_wdata;
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_done
    assign done_next[gi] = complete && (owner_reg == ((gi == 0) ? PORT_MEM : PORT_AUX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      l1_read_reg    <= 1'b0;
      l1_write_reg   <= 1'b0;
      done_reg       <= '0;
      starve_cnt_reg <= '0;
    end else begin
      done_reg <= done_next;

      if (|grant) begin
        state_reg    <= BUSY;
        l1_read_reg  <= !req_sel.we;
        l1_write_reg <= req_sel.we;
      end else if (launch) begin
        state_reg    <= IDLE;
        l1_read_reg  <= 1'b0;
        l1_write_reg <= 1'b0;
      end

      // Counts only memory-stage wins that actually made the aux side wait.
      if (grant[PORT_AUX]) begin
        starve_cnt_reg <= '0;
      end else if (grant[PORT_MEM]) begin
        if (!req1_valid) begin
          starve_cnt_reg <= '0;
        end else if (starve_cnt_reg != LIMIT) begin
          starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Datapath carries no reset; it is only meaningful alongside the strobes.
  always_ff @(posedge clk) begin
    if (|grant) begin
      req_lat_reg <= req_sel;
      owner_reg   <= grant[PORT_AUX] ? PORT_AUX : PORT_MEM;
    end
    if (complete && !req_lat_reg.we) begin
      rsp_rdata_reg <= l1_rdata;
    end
  end

  assign req0_grant = grant[PORT_MEM];
  assign req1_grant = grant[PORT_AUX];
  assign req0_done  = done_reg[PORT_MEM];
  assign req1_done  = done_reg[PORT_AUX];
  assign rsp_rdata  = rsp_rdata_reg;
  assign l1_addr    = req_lat_reg.addr;
  assign l1_wdata   = req_lat_reg.wdata;
  assign l1_read    = l1_read_reg;
  assign l1_write   = l1_write_reg;
  assign busy       = (state_reg == BUSY);

  // A pending request must stay valid with stable fields until it is granted.
  a_req0_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (req0_valid && !req0_grant) |=> (req0_valid && $stable({req0_we, req0_addr, req0_wdata})));
  a_req1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (req1_valid && !req1_grant) |=> (req1_valid && $stable({req1_we, req1_addr, req1_wdata})));
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(l1_read_reg && l1_write_reg));

endmodule

// File: tb/tb_riscv_l1d_port_arbiter.sv
// Directed bench for riscv_l1d_port_arbiter: single read, wait states,
// contention/starvation, streaming, idle aux request and mid-transaction reset.
module tb_riscv_l1d_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_grant, req1_grant, req0_done, req1_done;
  logic [31:0] rsp_rdata, l1_addr, l1_wdata, l1_rdata;
  logic        l1_read, l1_write, l1_ready, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_l1d_port_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_we   (req0_we),
    .req0_addr (req0_addr),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid),
    .req1_we   (req1_we),
    .req1_addr (req1_addr),
    .req1_wdata(req1_wdata),
    .req0_grant(req0_grant),
    .req1_grant(req1_grant),
    .req0_done (req0_done),
    .req1_done (req1_done),
    .rsp_rdata (rsp_rdata),
    .l1_addr   (l1_addr),
    .l1_read   (l1_read),
    .l1_write  (l1_write),
    .l1_wdata  (l1_wdata),
    .l1_rdata  (l1_rdata),
    .l1_ready  (l1_ready),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic single_read(input string tag);
    next_cycle();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h1000; req0_wdata = 32'h0;
    req1_valid = 1'b0; l1_ready = 1'b1; l1_rdata = 32'hDEADBEEF;
    sample();
    check_eq({tag, "_grant"}, 32'({req1_grant, req0_grant}), 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    sample();
    check_eq({tag, "_rd"},   32'({l1_read, l1_write}), 32'd2);
    check_eq({tag, "_addr"}, l1_addr, 32'h1000);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_nodone"}, 32'({req1_done, req0_done}), 32'd0);
    next_cycle();
    sample();
    check_eq({tag, "_done"},  32'({req1_done, req0_done}), 32'd1);
    check_eq({tag, "_rdata"}, rsp_rdata, 32'hDEADBEEF);
    check_eq({tag, "_idle"},  32'({busy, l1_read, l1_write}), 32'd0);
    next_cycle();
    sample();
    check_eq({tag, "_pulse"}, 32'({req1_done, req0_done}), 32'd0);
    $display("txn %s: req0 read 0x00001000 -> 0x%08h", tag, rsp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    logic [31:0] exp_g;
    logic [31:0] exp_d;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    l1_ready = 1'b1; l1_rdata = '0;
    next_cycle();
    next_cycle();
    sample();
    check_eq("rst_strobes", 32'({l1_read, l1_write}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'({req1_done, req0_done}), 32'd0);
    check_eq("rst_cnt", 32'(dut.starve_cnt_reg), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    single_read("single");

    // Aux write with three wait states.
    next_cycle();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h2004; req1_wdata = 32'h55;
    l1_ready = 1'b0; l1_rdata = 32'h12345678;
    sample();
    check_eq("ws_grant", 32'({req1_grant, req0_grant}), 32'd2);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req1_valid = 1'b0;
      l1_ready = (k == 3);
      sample();
      check_eq("ws_wr",    32'({l1_read, l1_write}), 32'd1);
      check_eq("ws_addr",  l1_addr, 32'h2004);
      check_eq("ws_wdata", l1_wdata, 32'h55);
      check_eq("ws_nodone", 32'({req1_done, req0_done}), 32'd0);
    end
    next_cycle();
    l1_ready = 1'b1;
    sample();
    check_eq("ws_done",  32'({req1_done, req0_done}), 32'd2);
    check_eq("ws_rdata", rsp_rdata, 32'hDEADBEEF);
    check_eq("ws_strobe_off", 32'({l1_read, l1_write}), 32'd0);
    next_cycle();
    sample();
    check_eq("ws_pulse", 32'({req1_done, req0_done}), 32'd0);
    $display("txn wait_states: req1 write 0x00002004 <- 0x00000055");

    // Contention: expected grants 0,0,0,0,1 repeating; done trails by two cycles.
    k0 = 0;
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h3000 + 32'(k0 * 4);
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h7000;
      l1_ready = 1'b1; l1_rdata = 32'h0;
      sample();
      exp_g = ((i % 5) == 4) ? 32'd2 : 32'd1;
      check_eq("cont_grant", 32'({req1_grant, req0_grant}), exp_g);
      if (i >= 2) begin
        exp_d = (((i - 2) % 5) == 4) ? 32'd2 : 32'd1;
        check_eq("cont_done", 32'({req1_done, req0_done}), exp_d);
      end
      if (exp_g == 32'd1) k0++;
      $display("txn contention %0d: grant vector %0d", i, {req1_grant, req0_grant});
    end
    next_cycle();
    req1_valid = 1'b0;
    req0_addr = 32'h3000 + 32'(k0 * 4);
    sample();
    check_eq("cont_tail_grant", 32'({req1_grant, req0_grant}), 32'd1);
    check_eq("cont_tail_done0", 32'({req1_done, req0_done}), 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    sample();
    check_eq("cont_tail_done1", 32'({req1_done, req0_done}), 32'd2);
    next_cycle();
    sample();
    check_eq("cont_tail_done2", 32'({req1_done, req0_done}), 32'd1);
    next_cycle();
    sample();
    check_eq("cont_tail_done3", 32'({req1_done, req0_done}), 32'd0);

    // Back-to-back streaming reads.
    for (int c = 0; c <= 10; c++) begin
      next_cycle();
      req0_valid = (c < 8); req0_we = 1'b0; req0_addr = 32'h4000 + 32'(c * 4);
      l1_ready = 1'b1; l1_rdata = 32'hA000_0000 + 32'(c - 1);
      sample();
      check_eq("b2b_grant", 32'(req0_grant), (c < 8) ? 32'd1 : 32'd0);
      check_eq("b2b_read", 32'({l1_read, l1_write}), ((c >= 1) && (c <= 8)) ? 32'd2 : 32'd0);
      if ((c >= 1) && (c <= 8)) check_eq("b2b_addr", l1_addr, 32'h4000 + 32'((c - 1) * 4));
      check_eq("b2b_done", 32'(req0_done), ((c >= 2) && (c <= 9)) ? 32'd1 : 32'd0);
      if ((c >= 2) && (c <= 9)) begin
        check_eq("b2b_rdata", rsp_rdata, 32'hA000_0000 + 32'(c - 2));
        $display("txn stream %0d: rdata 0x%08h", c - 2, rsp_rdata);
      end
    end

    // Aux request alone is granted immediately without counting starvation.
    next_cycle();
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h6000;
    l1_ready = 1'b1; l1_rdata = 32'hCAFEF00D;
    sample();
    check_eq("idle_grant", 32'({req1_grant, req0_grant}), 32'd2);
    next_cycle();
    req1_valid = 1'b0;
    sample();
    check_eq("idle_cnt", 32'(dut.starve_cnt_reg), 32'd0);
    check_eq("idle_read", 32'({l1_read, l1_write}), 32'd2);
    next_cycle();
    sample();
    check_eq("idle_done", 32'({req1_done, req0_done}), 32'd2);
    check_eq("idle_rdata", rsp_rdata, 32'hCAFEF00D);
    $display("txn idle_gap: req1 read 0x00006000 -> 0x%08h", rsp_rdata);

    // Reset while a read is stalled.
    next_cycle();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h5000; l1_ready = 1'b0;
    sample();
    check_eq("mid_grant", 32'({req1_grant, req0_grant}), 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    sample();
    check_eq("mid_busy_pre", 32'({busy, l1_read, l1_write}), 32'd6);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_off", 32'({busy, l1_read, l1_write}), 32'd0);
    next_cycle();
    l1_ready = 1'b1;
    sample();
    check_eq("mid_nodone0", 32'({req1_done, req0_done}), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    sample();
    check_eq("mid_nodone1", 32'({req1_done, req0_done}), 32'd0);
    check_eq("mid_idle", 32'(busy), 32'd0);
    $display("txn reset_mid_op: read to 0x00005000 abandoned");

    single_read("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
